// File: rtl/pc_next_gen.sv
// Next-address generator for the program counter.
// Owns the return-address stack, the run/halt/fault state and the sticky error flags.
module pc_next_gen #(
  parameter int                ADDR_W    = 6,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] FAULT_VEC = 6'h3F,
  localparam int               CNT_W     = $clog2(RAS_DEPTH) + 1,
  localparam int               PTR_W     = $clog2(RAS_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_off,
  input  logic              jmp,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] target,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  ras_cnt,
  output logic              ovf,
  output logic              unf
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] br_tgt;
  logic [CNT_W-1:0]  cnt_m1;
  logic [ADDR_W-1:0] ras_top;

  // Offset has full address width, so modular addition equals sign extension.
  assign inc     = pc_in + 1'b1;
  assign br_tgt  = inc + br_off;
  assign cnt_m1  = cnt_q - 1'b1;
  assign ras_top = ras_q[cnt_m1[PTR_W-1:0]];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    target  = inc;
    case (state_q)
      ST_RUN: begin
        if (halt) begin
          target  = pc_in;
          state_d = ST_HALT;
        end else if (stall) begin
          target = pc_in;
        end else if (ret) begin
          if (cnt_q != '0) begin
            target = ras_top;
            cnt_d  = cnt_m1;
          end else begin
            target  = pc_in;
            unf_d   = 1'b1;
            state_d = ST_FAULT;
          end
        end else if (call) begin
          if (cnt_q < DEPTH_C) begin
            target = jmp_addr;
            push   = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end else begin
            target  = pc_in;
            ovf_d   = 1'b1;
            state_d = ST_FAULT;
          end
        end else if (jmp) begin
          target = jmp_addr;
        end else if (br_taken) begin
          target = br_tgt;
        end
      end
      ST_HALT: begin
        target = pc_in;
        if (resume) state_d = ST_RUN;
      end
      default: begin
        target = FAULT_VEC;
      end
    endcase
    // Reset overrides combinationally so the PC loads 0 on the reset edge.
    if (!rst) begin
      target = '0;
      push   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_q[cnt_q[PTR_W-1:0]] <= inc;
  end

  assign halted  = (state_q == ST_HALT);
  assign fault   = (state_q == ST_FAULT);
  assign ras_cnt = cnt_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule
